// File: rtl/ads5404_ctrl.sv
// ads5404_ctrl: bring-up and supervision sequencer for the ADS5404 capture
// front end. Runs on a free-running fabric clock, sequences the capture
// block's reset/enable/sync, confirms the returned sync and restarts the
// whole sequence whenever PLL lock is lost while ready.
module ads5404_ctrl #(
    parameter int RST_CYCLES    = 1024,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int SETTLE_CYCLES = 256,
    parameter int SYNC_CYCLES   = 16,
    parameter int SYNC_WINDOW   = 64,
    parameter int CNTW          = 16
) (
    input  logic       clk,
    input  logic       user_rst_n,
    input  logic       start,
    input  logic       resync,
    input  logic       pll_locked,
    input  logic       sync_out_0,
    input  logic       sync_out_1,
    output logic       adc_rst,
    output logic       adc_enable,
    output logic       adc_sync,
    output logic       ready,
    output logic       lane_phase,
    output logic [2:0] state,
    output logic       err_timeout,
    output logic       err_nosync,
    output logic [7:0] relock_count
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_SYNC      = 3'd4,
        ST_WAIT_SYNC = 3'd5,
        ST_READY     = 3'd6,
        ST_FAULT     = 3'd7
    } state_t;

    // Counter reload values; each phase loads "length - 1" and exits at zero.
    localparam logic [CNTW-1:0] LD_RST    = CNTW'(RST_CYCLES - 1);
    localparam logic [CNTW-1:0] LD_LOCK   = CNTW'(LOCK_TIMEOUT - 1);
    localparam logic [CNTW-1:0] LD_SETTLE = CNTW'(SETTLE_CYCLES - 1);
    localparam logic [CNTW-1:0] LD_SYNC   = CNTW'(SYNC_CYCLES - 1);
    localparam logic [CNTW-1:0] LD_WIN    = CNTW'(SYNC_WINDOW - 1);
    localparam logic [CNTW-1:0] CNT_ZERO  = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] CNT_ONE   = {{(CNTW-1){1'b0}}, 1'b1};

    // Saturating 8-bit increment for the lock-loss counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

    state_t          r_state;
    logic [CNTW-1:0] r_cnt;
    logic [4:0]      r_meta;
    logic [4:0]      r_sync;
    logic            r_adc_rst;
    logic            r_adc_enable;
    logic            r_adc_sync;
    logic            r_ready;
    logic            r_lane_phase;
    logic            r_err_timeout;
    logic            r_err_nosync;
    logic [7:0]      r_relock_count;
    logic            r_seen;

    logic w_start;
    logic w_resync;
    logic w_lock;
    logic w_so0;
    logic w_so1;
    logic w_sync_any;
    logic w_lane;
    logic w_cnt_zero;
    logic w_detect_win;

    assign w_start      = r_sync[4];
    assign w_resync     = r_sync[3];
    assign w_lock       = r_sync[2];
    assign w_so1        = r_sync[1];
    assign w_so0        = r_sync[0];
    assign w_sync_any   = w_so0 | w_so1;
    assign w_lane       = w_so1 & ~w_so0;
    assign w_cnt_zero   = (r_cnt == CNT_ZERO);
    assign w_detect_win = (r_state == ST_SYNC) || (r_state == ST_WAIT_SYNC);

    // Two-flop synchronisers for every input (all inputs share the same latency).
    always_ff @(posedge clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_meta <= 5'b00000;
            r_sync <= 5'b00000;
        end else begin
            r_meta <= {start, resync, pll_locked, sync_out_1, sync_out_0};
            r_sync <= r_meta;
        end
    end

    // Bring-up sequencer: state, shared down-counter, registered outputs and flags.
    always_ff @(posedge clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= CNT_ZERO;
            r_adc_rst      <= 1'b1;
            r_adc_enable   <= 1'b0;
            r_adc_sync     <= 1'b0;
            r_ready        <= 1'b0;
            r_lane_phase   <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_nosync   <= 1'b0;
            r_relock_count <= 8'd0;
            r_seen         <= 1'b0;
        end else begin
            // First returned sync after the pulse starts fixes the lane phase;
            // both lanes high together counts as the even lane.
            if (w_detect_win && !r_seen && w_sync_any) begin
                r_seen       <= 1'b1;
                r_lane_phase <= w_lane;
            end else begin
                r_seen <= r_seen;
            end

            if (w_start) begin
                r_state      <= ST_RESET;
                r_cnt        <= LD_RST;
                r_adc_rst    <= 1'b1;
                r_adc_enable <= 1'b0;
                r_adc_sync   <= 1'b0;
                r_ready      <= 1'b0;
                if ((r_state == ST_IDLE) || (r_state == ST_FAULT)) begin
                    r_err_timeout <= 1'b0;
                    r_err_nosync  <= 1'b0;
                end else begin
                    r_err_timeout <= r_err_timeout;
                    r_err_nosync  <= r_err_nosync;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_adc_rst <= 1'b1;
                    end
                    ST_RESET: begin
                        if (w_cnt_zero) begin
                            r_state   <= ST_WAIT_LOCK;
                            r_cnt     <= LD_LOCK;
                            r_adc_rst <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (w_lock) begin
                            r_state <= ST_SETTLE;
                            r_cnt   <= LD_SETTLE;
                        end else if (w_cnt_zero) begin
                            r_state       <= ST_FAULT;
                            r_err_timeout <= 1'b1;
                            r_adc_rst     <= 1'b1;
                            r_adc_enable  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                    ST_SETTLE: begin
                        if (!w_lock) begin
                            r_state      <= ST_RESET;
                            r_cnt        <= LD_RST;
                            r_adc_rst    <= 1'b1;
                            r_adc_enable <= 1'b0;
                        end else if (w_cnt_zero) begin
                            r_state      <= ST_SYNC;
                            r_cnt        <= LD_SYNC;
                            r_adc_enable <= 1'b1;
                            r_adc_sync   <= 1'b1;
                            r_seen       <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                    ST_SYNC: begin
                        if (w_cnt_zero) begin
                            r_state    <= ST_WAIT_SYNC;
                            r_cnt      <= LD_WIN;
                            r_adc_sync <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                    ST_WAIT_SYNC: begin
                        if (r_seen || w_sync_any) begin
                            r_state <= ST_READY;
                            r_ready <= 1'b1;
                        end else if (w_cnt_zero) begin
                            r_state      <= ST_FAULT;
                            r_err_nosync <= 1'b1;
                            r_adc_rst    <= 1'b1;
                            r_adc_enable <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                    ST_READY: begin
                        // Lock loss outranks a resync request arriving in the same cycle.
                        if (!w_lock) begin
                            r_state        <= ST_RESET;
                            r_cnt          <= LD_RST;
                            r_relock_count <= sat_inc8(r_relock_count);
                            r_ready        <= 1'b0;
                            r_adc_rst      <= 1'b1;
                            r_adc_enable   <= 1'b0;
                        end else if (w_resync) begin
                            r_state    <= ST_SYNC;
                            r_cnt      <= LD_SYNC;
                            r_adc_sync <= 1'b1;
                            r_ready    <= 1'b0;
                            r_seen     <= 1'b0;
                        end else begin
                            r_ready <= 1'b1;
                        end
                    end
                    ST_FAULT: begin
                        r_adc_rst    <= 1'b1;
                        r_adc_enable <= 1'b0;
                    end
                    default: begin
                        r_state      <= ST_IDLE;
                        r_adc_rst    <= 1'b1;
                        r_adc_enable <= 1'b0;
                        r_adc_sync   <= 1'b0;
                        r_ready      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign adc_rst      = r_adc_rst;
    assign adc_enable   = r_adc_enable;
    assign adc_sync     = r_adc_sync;
    assign ready        = r_ready;
    assign lane_phase   = r_lane_phase;
    assign state        = r_state;
    assign err_timeout  = r_err_timeout;
    assign err_nosync   = r_err_nosync;
    assign relock_count = r_relock_count;

endmodule

// File: doc/ads5404_ctrl.md
Name: ads5404_ctrl

Overview:
- Bring-up and supervision sequencer for the ADS5404 capture front end.
- Drives the capture block's reset, enable and sync inputs in order. Waits for PLL lock, issues a sync pulse and confirms it returns on the syncout lanes.
- Raises `ready` for downstream user logic and automatically restarts the sequence on PLL lock loss.
- Runs on a free-running fabric clock, independent of the ADC-derived clkout, so it keeps operating while the PLL is held in reset.

Parameters:
- RST_CYCLES, 1024: cycles `adc_rst` is held high in RESET.
- LOCK_TIMEOUT, 65535: maximum cycles spent in WAIT_LOCK before FAULT.
- SETTLE_CYCLES, 256: cycles after lock before `adc_enable` and sync.
- SYNC_CYCLES, 16: width of the `adc_sync` pulse.
- SYNC_WINDOW, 64: cycles after the sync pulse ends in which returned sync must be seen.
- CNTW, 16: width of the shared down-counter; must hold the largest of the above.

Ports:
- clk  input  1  free-running control clock
- user_rst_n  input  1  asynchronous active-low reset
- start  input  1  pulse: begin or restart the bring-up sequence
- resync  input  1  pulse: re-issue sync only (honoured in READY)
- pll_locked  input  1  lock from the capture block; asynchronous, double-flop synchronised internally
- sync_out_0  input  1  returned sync, even lane; double-flop synchronised
- sync_out_1  input  1  returned sync, odd lane; double-flop synchronised
- adc_rst  output  1  active-high reset to the capture block
- adc_enable  output  1  ADC enable
- adc_sync  output  1  sync request to the capture block
- ready  output  1  high only in READY
- lane_phase  output  1  lane on which returned sync was first seen (0 = even, 1 = odd)
- state  output  3  current state encoding
- err_timeout  output  1  sticky: lock timeout occurred
- err_nosync  output  1  sticky: sync did not return
- relock_count  output  8  saturating count of lock-loss events seen in READY

Behaviour:
- Reset values: state = IDLE, `adc_rst` = 1, `adc_enable` = 0, `adc_sync` = 0, `ready` = 0, `lane_phase` = 0, errors = 0, `relock_count` = 0, counter = 0, synchroniser flops = 0.
- All outputs are registered. Inputs are used only after the 2-flop synchronisers (2-cycle input latency).
- State encoding: IDLE=0, RESET=1, WAIT_LOCK=2, SETTLE=3, SYNC=4, WAIT_SYNC=5, READY=6, FAULT=7.
- IDLE: `adc_rst` = 1. On `start` -> RESET; counter loaded with RST_CYCLES-1.
- RESET: `adc_rst` = 1, `adc_enable` = 0. Counter decrements; at 0 -> WAIT_LOCK, counter = LOCK_TIMEOUT-1, `adc_rst` = 0.
- WAIT_LOCK: synchronised lock high -> SETTLE, counter = SETTLE_CYCLES-1. Counter reaching 0 without lock -> FAULT, `err_timeout` set.
- SETTLE: lock loss -> RESET (reload). Counter 0 -> SYNC, counter = SYNC_CYCLES-1, `adc_enable` = 1.
- SYNC: `adc_sync` = 1 for exactly SYNC_CYCLES cycles. Then -> WAIT_SYNC, counter = SYNC_WINDOW-1, `adc_sync` = 0.
- WAIT_SYNC: sync detection starts at SYNC entry.
  - On the first cycle either synchronised sync_out is high, capture `lane_phase`: 1 only if sync_out_1=1 and sync_out_0=0; both high gives 0.
  - If detected, go to READY at the end of WAIT_SYNC entry +1 cycle.
  - Window expiry with no detection -> FAULT, `err_nosync` set.
- READY: `ready` = 1.
  - `resync` -> SYNC, with `adc_enable` held high.
  - Lock loss -> RESET, `relock_count` +1 saturating at 255, `ready` drops in the same registered transition.
- FAULT: `adc_rst` = 1, `adc_enable` = 0. Stays until `start` -> RESET.
- Error flags clear only on reset or on `start` accepted from IDLE/FAULT.
- Priority: `start` beats every other event in every state except RESET, where it reloads the counter. Lock loss beats `resync` when both occur in the same cycle. `resync` outside READY is ignored.
- Asserting `user_rst_n` low mid-sequence forces the reset values asynchronously; the sequence does not resume on release.

Test Plan:
- Reset, `start`; lock rises 100 cycles after `adc_rst` falls; sync echoed on lane 0 ten cycles after `adc_sync` -> `adc_rst` high for exactly 1024 cycles, `adc_sync` high for 16, `ready`=1, `lane_phase`=0, state=6.
- Lock held low -> FAULT 65535 cycles after WAIT_LOCK entry, `err_timeout`=1, `adc_rst`=1; then `start` -> errors clear and state=1.
- Sync echoed only on sync_out_1 -> `lane_phase`=1. No echo at all -> FAULT after the 64-cycle window, `err_nosync`=1.
- In READY, drop lock for 5 cycles, three times -> `relock_count`=3, full re-bring-up each time. Force 300 losses -> count saturates at 255.
- In READY, pulse `resync` -> single 16-cycle `adc_sync`, `adc_enable` stays 1, returns to READY. `resync` together with lock loss -> RESET.
- Pull `user_rst_n` low during SYNC -> `adc_sync`=0 and `adc_rst`=1 immediately (async); state=0 after release.
